// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder controller that time-shares one external
//   4-bit lookahead adder slice. Each add is processed one nibble per clock,
//   least significant nibble first, with the slice carry-out fed back as the
//   carry-in of the next nibble.
//
// Ports
//   CLK    in   1      rising-edge clock
//   RST_n  in   1      asynchronous active-low reset
//   start  in   1      request an add; only looked at while idle
//   A, B   in   WIDTH  operands, captured on the accepted start
//   C0     in   1      carry-in, captured on the accepted start
//   busy   out  1      high while an add is running or completing
//   done   out  1      one-cycle pulse when F/CO/OVF are valid
//   F      out  WIDTH  sum, held until the next add overwrites it
//   CO     out  1      carry-out of the most significant nibble
//   OVF    out  1      two's-complement overflow of the add
//   SA, SB out  4      operand nibbles presented to the slice
//   SC0    out  1      carry-in presented to the slice
//   SF     in   4      slice sum (combinational from SA/SB/SC0)
//   SC4    in   1      slice carry-out

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             CO,
    output logic             OVF,
    output logic [3:0]       SA,
    output logic [3:0]       SB,
    output logic             SC0,
    input  logic [3:0]       SF,
    input  logic             SC4
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic               last_nib;

    assign idx_next = idx + 1'b1;
    assign last_nib = (idx == IDX_W'(NIB - 1));

    // Single FSM block. The slice operands are registered: on each edge we
    // load the nibble the slice will work on during the following cycle, so
    // the slice never sees a combinational path from A/B. The slice carry-out
    // goes straight into SC0 so the next nibble continues the carry chain.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            F     <= '0;
            CO    <= 1'b0;
            OVF   <= 1'b0;
            SA    <= 4'h0;
            SB    <= 4'h0;
            SC0   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= C0;
                        idx   <= '0;
                        SA    <= A[3:0];
                        SB    <= B[3:0];
                        SC0   <= C0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    F[4*idx +: 4] <= SF;
                    carry         <= SC4;
                    if (last_nib) begin
                        // Overflow: operands share a sign but the top sum
                        // bit from the slice disagrees with it.
                        CO    <= SC4;
                        OVF   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (SF[3] != a_reg[WIDTH-1]);
                        idx   <= '0;
                        SA    <= 4'h0;
                        SB    <= 4'h0;
                        SC0   <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx_next;
                        SA    <= a_reg[4*idx_next +: 4];
                        SB    <= b_reg[4*idx_next +: 4];
                        SC0   <= SC4;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//   Self-checking bench for nibble_serial_adder (WIDTH=16). The 4-bit slice
//   is modelled as a plain 5-bit addition. A reference model tracks each add
//   as a phase counter and predicts results with full-width arithmetic; a
//   compare process checks the DUT on every falling edge, and directed
//   scenarios pin the model with hand-computed literals.

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c0_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f_out;
    logic             co_out;
    logic             ovf_out;
    logic [3:0]       sa;
    logic [3:0]       sb;
    logic             sc0;
    logic [3:0]       sf;
    logic             sc4;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .C0    (c0_in),
        .busy  (busy),
        .done  (done),
        .F     (f_out),
        .CO    (co_out),
        .OVF   (ovf_out),
        .SA    (sa),
        .SB    (sb),
        .SC0   (sc0),
        .SF    (sf),
        .SC4   (sc4)
    );

    // 4-bit adder slice
    assign {sc4, sf} = {1'b0, sa} + {1'b0, sb} + {4'b0000, sc0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] full_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    // Carry entering nibble k of a+b+c
    function automatic logic carry_into(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic c, input int k);
        logic [WIDTH:0] mask;
        logic [WIDTH:0] s;
        if (k == 0) return c;
        mask = ((WIDTH+1)'(1) << (4*k)) - 1'b1;
        s = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{WIDTH{1'b0}}, c};
        return s[4*k];
    endfunction

    // Reference model: ph=0 idle, 1..NIB presenting nibble ph-1, NIB+1 done.
    int               ph;
    logic [WIDTH-1:0] m_a, m_b;
    logic             m_c0;
    logic [WIDTH-1:0] exp_f;
    logic             exp_co, exp_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph      <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_c0    <= 1'b0;
            exp_f   <= '0;
            exp_co  <= 1'b0;
            exp_ovf <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph   <= 1;
                m_a  <= a_in;
                m_b  <= b_in;
                m_c0 <= c0_in;
            end
        end else if (ph == NIB) begin
            ph      <= NIB + 1;
            exp_f   <= full_sum(m_a, m_b, m_c0)[WIDTH-1:0];
            exp_co  <= full_sum(m_a, m_b, m_c0)[WIDTH];
            exp_ovf <= (m_a[WIDTH-1] == m_b[WIDTH-1]) &&
                       (full_sum(m_a, m_b, m_c0)[WIDTH-1] != m_a[WIDTH-1]);
        end else if (ph == NIB + 1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    // Compare DUT against model every falling edge while out of reset
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_val("busy", 32'(busy), 32'(ph != 0));
            check_val("done", 32'(done), 32'(ph == NIB + 1));
            if (ph == 0 || ph == NIB + 1) begin
                check_val("F", 32'(f_out), 32'(exp_f));
                check_val("CO", 32'(co_out), 32'(exp_co));
                check_val("OVF", 32'(ovf_out), 32'(exp_ovf));
            end
            if (ph == 0) begin
                check_val("SA_idle", 32'(sa), 32'h0);
                check_val("SB_idle", 32'(sb), 32'h0);
                check_val("SC0_idle", 32'(sc0), 32'h0);
            end else if (ph <= NIB) begin
                check_val("SA_run", 32'(sa), 32'(m_a[4*(ph-1) +: 4]));
                check_val("SB_run", 32'(sb), 32'(m_b[4*(ph-1) +: 4]));
                check_val("SC0_run", 32'(sc0), 32'(carry_into(m_a, m_b, m_c0, ph - 1)));
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        c0_in = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done after the accepting edge and checks literals
    task automatic checkOutput(input logic [WIDTH-1:0] f, input logic co,
                               input logic ovf, input string name);
        int n = 0;
        bit found = 0;
        while (n < 20 && !found) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) found = 1;
        end
        check_val({name, "_latency"}, 32'(n), 32'd5);
        check_val({name, "_F"}, 32'(f_out), 32'(f));
        check_val({name, "_CO"}, 32'(co_out), 32'(co));
        check_val({name, "_OVF"}, 32'(ovf_out), 32'(ovf));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int done_cnt;
        int first_done;
        int last_done;
        logic [WIDTH-1:0] f_at_done;
        logic co_at_done;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c0_in = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        check_val("rst_F", 32'(f_out), 32'h0);
        check_val("rst_SA", 32'(sa), 32'h0);
        rst_n = 1'b1;

        $display("[TB] basic adds");
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        checkOutput(16'h5555, 1'b0, 1'b0, "t1");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput(16'h0000, 1'b1, 1'b0, "t2");
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        checkOutput(16'h8000, 1'b0, 1'b1, "t3a");
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        checkOutput(16'hFFFF, 1'b1, 1'b0, "t3b");

        $display("[TB] starts while busy");
        @(negedge clk);
        a_in  = 16'h0F0F;
        b_in  = 16'h00F1;
        c0_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt   = 0;
        f_at_done  = '0;
        co_at_done = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                f_at_done  = f_out;
                co_at_done = co_out;
            end
            if (i == 2) begin
                a_in  = 16'hFFFF;
                b_in  = 16'hFFFF;
                c0_in = 1'b1;
                start = 1'b1;
            end else if (i == 5) begin
                a_in  = 16'h1111;
                b_in  = 16'h2222;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check_val("t4_done_count", 32'(done_cnt), 32'd1);
        check_val("t4_F", 32'(f_at_done), 32'h1000);
        check_val("t4_CO", 32'(co_at_done), 32'h0);

        $display("[TB] reset mid-add");
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_busy", 32'(busy), 32'h0);
        check_val("t5_done", 32'(done), 32'h0);
        check_val("t5_F", 32'(f_out), 32'h0);
        check_val("t5_CO", 32'(co_out), 32'h0);
        check_val("t5_OVF", 32'(ovf_out), 32'h0);
        check_val("t5_SA", 32'(sa), 32'h0);
        check_val("t5_SB", 32'(sb), 32'h0);
        check_val("t5_SC0", 32'(sc0), 32'h0);
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check_val("t5_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        applyStimulus(16'h0004, 16'h0003, 1'b0);
        checkOutput(16'h0007, 1'b0, 1'b0, "t5_after");

        $display("[TB] back-to-back");
        @(negedge clk);
        a_in  = 16'h8000;
        b_in  = 16'h8000;
        c0_in = 1'b0;
        start = 1'b1;
        done_cnt   = 0;
        first_done = 0;
        last_done  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_done = i;
                    check_val("t6_first_F", 32'(f_out), 32'h0000);
                    check_val("t6_first_CO", 32'(co_out), 32'h1);
                    check_val("t6_first_OVF", 32'(ovf_out), 32'h1);
                end else begin
                    check_val("t6_interval", 32'(i - last_done), 32'd6);
                end
                last_done = i;
            end
            a_in  = 16'(i * 16'h0913 + 16'h7F00);
            b_in  = 16'(i * 16'h1357);
            c0_in = 1'(i % 2);
        end
        check_val("t6_first_latency", 32'(first_done), 32'd5);
        check_val("t6_done_count", 32'(done_cnt), 32'd3);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
